// File: rtl/dbus_sram_resp_pkg.sv
// Shared dBUS request/response types plus the responder FSM state encoding.
package common;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dbus_sram_state_t;

  // Natural alignment: an N-byte access must sit on an N-byte boundary.
  function automatic logic misaligned_access(msize_t size, logic [2:0] lo);
    case (size)
      MSIZE2:  return lo[0];
      MSIZE4:  return |lo[1:0];
      MSIZE8:  return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dbus_sram_resp_sram_bank.sv
// 64-bit word SRAM: combinational read by index, byte-enable write on the rising edge.
// Contents are deliberately not reset.
module sram_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx_i,
  input  logic [7:0]    we_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH_WORDS];

  assign rdata_o = mem_q[idx_i];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dbus_sram_resp.sv
// dBUS responder over a local SRAM; DBUS_SRAM_ALIGN_CHECK_EN adds misalignment reporting on err.
// Latency: data_ok exactly LATENCY cycles after the addr_ok cycle, one request in flight.
// Backpressure: addr_ok only in IDLE, so the next accept is at least LATENCY+1 cycles later.
module dbus_sram_resp
  import common::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  dbus_sram_state_t state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [63:0]      addr_q, addr_d;
  msize_t           size_q, size_d;
  logic [7:0]       strobe_q, strobe_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             addr_ok;
  logic             misaligned;
  logic [AW-1:0]    bank_idx;
  logic [7:0]       bank_we;
  logic [63:0]      bank_rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    addr_ok  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          addr_ok  = 1'b1;
          addr_d   = dreq.addr;
          size_d   = dreq.size;
          strobe_d = dreq.strobe;
          wdata_d  = dreq.data;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The _d capture values equal dreq on a LATENCY==1 accept, so the RESP-entry edge never needs a bypass.
  assign bank_idx = AW'((addr_d - BASE_ADDR) >> 3);

`ifdef DBUS_SRAM_ALIGN_CHECK_EN
  assign misaligned = misaligned_access(size_d, addr_d[2:0]);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    rdata_d = rdata_q;
    err_d   = 1'b0;
    bank_we = 8'h00;
    if (state_d == RESP) begin
      rdata_d = (misaligned || (strobe_d != 8'h00)) ? 64'h0 : bank_rdata;
      err_d   = misaligned;
      // The SRAM has no reset, so a reset landing on the commit edge must veto the write here.
      if (!misaligned && resetn) bank_we = strobe_d;
    end
  end

  sram_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bank (
    .clk    (clk),
    .idx_i  (bank_idx),
    .we_i   (bank_we),
    .wdata_i(wdata_d),
    .rdata_o(bank_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 64'h0;
      size_q   <= MSIZE1;
      strobe_q <= 8'h00;
      wdata_q  <= 64'h0;
      rdata_q  <= 64'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign dresp.addr_ok = addr_ok & resetn;
  assign dresp.data_ok = (state_q == RESP);
  assign dresp.data    = rdata_q;
  assign err           = err_q;

endmodule

// File: doc/dbus_sram_resp.md
# dbus_sram_resp

Responder end of the data bus: accepts `dbus_req_t` requests issued by the memory-stage initiator and answers on `dbus_resp_t` after a fixed, parameterised latency. It is backed by a local 64-bit-wide byte-writable SRAM. It serves as the simulation/FPGA data memory behind the core's dBUS and as a latency-controllable target for initiator verification.

## Interface
- `DEPTH_WORDS`, 1024: number of 64-bit words; power of two.
- `LATENCY`, 2: cycles from accept cycle to `data_ok` cycle; legal range 1..15.
- `BASE_ADDR`, 64'h8000_0000: address mapped to word 0.
- `clk` in 1: single clock, all logic on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `dreq` in `dbus_req_t`: `valid`, `addr[63:0]`, `size` (`msize_t`), `strobe[7:0]` (all zero means read), `data[63:0]` (already lane-aligned).
- `dresp` out `dbus_resp_t`: `addr_ok`, `data_ok`, `data[63:0]` (full aligned 64-bit word).
- `err` out 1: misalignment flag, valid with `data_ok`.

## Operation
- Word index = `(addr - BASE_ADDR) >> 3`, truncated to log2(`DEPTH_WORDS`) bits; out-of-range addresses wrap, no error.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if `dreq.valid`, capture addr/size/strobe/data. If `LATENCY`==1, go to RESP; otherwise go to WAIT with `cnt` = `LATENCY`-2.
  - WAIT: if `cnt`==0, go to RESP; else `cnt` decrements. `dreq` is ignored.
  - RESP: always go to IDLE.
- `addr_ok` = (state==IDLE) & `dreq.valid`, combinational. It is the only combinational output.
- `data_ok`: registered, high exactly during RESP.
- On the edge entering RESP:
  - Write (strobe≠0): byte lanes with `strobe[i]`=1 take `data[8i+7:8i]`; other lanes are unchanged. `dresp.data` loads 0.
  - Read: `dresp.data` loads the stored word.
- `dresp.data` holds its value until the next RESP entry.
- The initiator keeps `valid` high through the `data_ok` cycle. A request still valid in the IDLE cycle after RESP is accepted as a new request.
- `size` is not used for lane selection. Strobe alone defines written bytes. Reads always return the whole word.
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values: state IDLE, `cnt` 0, `addr_ok` 0 (combinational on IDLE & valid), `data_ok` 0, `dresp.data` 0, `err` 0.
- Cycle numbering: accept cycle = cycle 0, `data_ok` in cycle `LATENCY`. Minimum spacing of two accepts = `LATENCY`+1 cycles.
- Reset asserted in WAIT or in the entry edge to RESP: request is dropped, no memory write, `data_ok` is never raised. Captured write data is discarded.
- A read following a write to the same word sees the written data, because the write commits at the RESP entry edge.
- `valid` dropping during WAIT does not abort the request; the response is still delivered.

## Configuration
- `DBUS_SRAM_ALIGN_CHECK_EN` defined:
  - Captured request is misaligned when:
    - `MSIZE2` and `addr[0]`≠0;
    - `MSIZE4` and `addr[1:0]`≠0;
    - `MSIZE8` and `addr[2:0]`≠0.
  - A misaligned request still takes the normal FSM path.
  - No memory write occurs, and `dresp.data` loads 0.
  - `err`=1 during its RESP cycle only.
- Undefined: `err` is tied 0. All accesses proceed as in Operation, with strobe defining the bytes written.

## Structure
- `common` package already provides `dbus_req_t`, `dbus_resp_t`, `msize_t`, `MSIZE1/2/4/8`.
- Add `dbus_sram_state_t` (IDLE/WAIT/RESP enum) to `common`.
- Sub-module `sram_bank`: `DEPTH_WORDS`×64 array, combinational read by index, synchronous byte-enable write (8-bit `we`). `dbus_sram_resp` holds the FSM, counter, capture registers and error check.

## Test plan
- Reset: hold `resetn`=0 with `dreq.valid`=1 → `addr_ok`=0, `data_ok`=0, `dresp.data`=0, `err`=0. After release, the first request is accepted in the cycle after release.
- `sd` 0x1122334455667788 to 0x8000_0008, strobe 8'hFF, `LATENCY`=2 → `addr_ok` in cycle 0, `data_ok` only in cycle 2. A following `ld` 0x8000_0008 returns 0x1122334455667788 with `data_ok` 2 cycles after its accept.
- Pre-load word 0x8000_0010 = 0, then `sb` with strobe 8'h08, data[31:24]=0xAB → `ld` 0x8000_0010 returns 0x00000000AB000000. Address 0x8000_0010+`DEPTH_WORDS`×8 returns the same word (wrap).
- Back-to-back: `valid` held high across three reads, `LATENCY`=1 → `addr_ok` in cycles 0,2,4; `data_ok` in cycles 1,3,5; `addr_ok`=0 in RESP cycles.
- Pre-load word 0x8000_0020 = 0x5555 (so the old value is known). Issue `sd` 0xFFFF to 0x8000_0020 and assert `resetn`=0 during WAIT (`LATENCY`=3) → no `data_ok`. After reset, `ld` returns the prior value 0x5555.
- With `DBUS_SRAM_ALIGN_CHECK_EN`: `lw` at 0x8000_0002 → `err`=1 and `data_ok`=1 in the same cycle, data 0. `sw` at 0x8000_0006 → `err`=1 and memory is unchanged.
